// File: rtl/conv_pkg.sv
// conv_pkg: definitions shared by the convolution, pooling and FC blocks.
//   DATA_BITS_DEF / SUM_BITS_DEF : default pixel and accumulator widths
//   tap_idx     : flat index of window tap (r,c) for a KxK window
//   round_shift : round-half-up arithmetic right shift
//   sat_clip    : clip to a signed OUT_BITS range, flagging when clipped
// Requantisation runs in a 64-bit signed word. Any accumulator of up to
// 62 bits plus its rounding offset fits in it without overflow.
package conv_pkg;

  localparam int DATA_BITS_DEF = 8;
  localparam int SUM_BITS_DEF  = 24;
  localparam int WIDE_BITS     = 64;

  typedef logic signed [WIDE_BITS-1:0] wide_t;

  function automatic int tap_idx(input int r, input int c, input int k);
    return r * k + c;
  endfunction

  // Adds half an LSB of the result before shifting. A shift of 0 passes
  // the value through unchanged.
  function automatic wide_t round_shift(input wide_t v, input logic [4:0] sh);
    wide_t half;
    half = (sh == 5'd0) ? '0 : (wide_t'(1) <<< (sh - 5'd1));
    return (v + half) >>> sh;
  endfunction

  function automatic wide_t sat_clip(input wide_t r, input int out_bits,
                                     output logic clipped);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (out_bits - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    clipped = 1'b0;
    if (r > hi) begin
      clipped = 1'b1;
      return hi;
    end
    if (r < lo) begin
      clipped = 1'b1;
      return lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_requant.sv
// conv_requant: output stage. It applies optional ReLU, a rounding right
// shift and saturation, and holds the result in a registered output.
//   clk, rst_n   : clock, async active-low reset
//   en           : pipeline enable (hold everything when low)
//   in_valid     : fin/relu_en/shift carry a finished sum this cycle
//   fin          : signed sum (accumulator + bias)
//   relu_en      : clamp negative sums to zero before shifting
//   shift        : right-shift amount
//   valid_out    : y/sat valid
//   y, sat       : requantised result and clip flag
module conv_requant
  import conv_pkg::*;
#(
  parameter int SUM_BITS = SUM_BITS_DEF,
  parameter int OUT_BITS = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       in_valid,
  input  logic signed [SUM_BITS-1:0] fin,
  input  logic                       relu_en,
  input  logic [4:0]                 shift,
  output logic                       valid_out,
  output logic signed [OUT_BITS-1:0] y,
  output logic                       sat
);

  logic signed [OUT_BITS-1:0] y_next;
  logic                       sat_next;

  always_comb begin
    wide_t v;
    wide_t r;
    logic  clip;
    clip = 1'b0;
    v = wide_t'(fin);
    if (relu_en && fin[SUM_BITS-1]) v = '0;
    r = round_shift(v, shift);
    y_next = OUT_BITS'(sat_clip(r, OUT_BITS, clip));
    sat_next = clip;
  end

  // When no new result arrives, y/sat keep their last value. A stalled
  // output therefore stays stable until the downstream side takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      y         <= '0;
      sat       <= 1'b0;
    end else if (en) begin
      valid_out <= in_valid;
      if (in_valid) begin
        y   <= y_next;
        sat <= sat_next;
      end
    end
  end

endmodule

// File: rtl/conv_kxk_mc_filter.sv
// conv_kxk_mc_filter: computes one output pixel from a KxK window
// convolution summed over C_IN channels, one channel per beat.
//   clk, rst_n           : clock, async active-low reset
//   valid_in / ready_out : input beat handshake (pix, kern, bias, relu_en, shift)
//   pix, kern            : KxK taps, tap (r,c) at [(r*K+c)*DATA_BITS +: DATA_BITS]
//   bias, relu_en, shift : requant controls, used from the last-channel beat
//   valid_out / ready_in : output handshake for y and sat
//   y, sat               : signed result and clip flag
// Handshake: a transfer happens on a rising edge where valid && ready.
// Once valid_out is raised, y/sat hold until ready_in takes them.
// ready_out = !valid_out || ready_in. It does not depend on valid_in. When
// it is low, every pipeline stage, the accumulator and the channel counter
// hold.
// Pipeline: S1 products -> S2 row sums -> S3 accumulate/bias -> S4 requant.
module conv_kxk_mc_filter
  import conv_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int K         = 5,
  parameter int C_IN      = 3,
  parameter int SUM_BITS  = SUM_BITS_DEF,
  parameter int OUT_BITS  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_in,
  output logic                         ready_out,
  input  logic [K*K*DATA_BITS-1:0]     pix,
  input  logic [K*K*DATA_BITS-1:0]     kern,
  input  logic signed [SUM_BITS-1:0]   bias,
  input  logic                         relu_en,
  input  logic [4:0]                   shift,
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic signed [OUT_BITS-1:0]   y,
  output logic                         sat
);

  localparam int TAPS = K * K;
  localparam int CH_W = (C_IN > 1) ? $clog2(C_IN) : 1;
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(C_IN - 1);

  logic            en;
  logic            accept;
  logic [CH_W-1:0] ch;
  logic            first_in;
  logic            last_in;

  assign en        = !valid_out || ready_in;
  assign ready_out = en;
  assign accept    = valid_in && en;
  assign first_in  = (ch == '0);
  assign last_in   = (ch == CH_LAST);

  // S1 combinational: per-tap signed products, sign-extended.
  logic signed [SUM_BITS-1:0] prod_c [TAPS];

  for (genvar r = 0; r < K; r++) begin : g_row_prod
    for (genvar c = 0; c < K; c++) begin : g_tap
      localparam int T = tap_idx(r, c, K);
      logic signed [2*DATA_BITS-1:0] p;
      assign p = $signed(pix[T*DATA_BITS +: DATA_BITS]) *
                 $signed(kern[T*DATA_BITS +: DATA_BITS]);
      assign prod_c[T] = SUM_BITS'(p);
    end
  end

  logic                       s1_v, s1_first, s1_last, s1_relu;
  logic signed [SUM_BITS-1:0] s1_bias;
  logic [4:0]                 s1_shift;
  logic signed [SUM_BITS-1:0] s1_prod [TAPS];

  // S2 combinational: one sum per window row.
  logic signed [SUM_BITS-1:0] row_c [K];

  for (genvar r = 0; r < K; r++) begin : g_row_sum
    logic signed [SUM_BITS-1:0] rs;
    always_comb begin
      rs = '0;
      for (int c = 0; c < K; c++) rs = rs + s1_prod[tap_idx(r, c, K)];
    end
    assign row_c[r] = rs;
  end

  logic                       s2_v, s2_first, s2_last, s2_relu;
  logic signed [SUM_BITS-1:0] s2_bias;
  logic [4:0]                 s2_shift;
  logic signed [SUM_BITS-1:0] s2_row [K];

  // S3 combinational: window sum folded into the channel accumulator.
  // A first-channel beat restarts the accumulator, so stale partial sums
  // never leak into a new output.
  logic signed [SUM_BITS-1:0] acc, acc_next;

  always_comb begin
    logic signed [SUM_BITS-1:0] wsum;
    wsum = '0;
    for (int r = 0; r < K; r++) wsum = wsum + s2_row[r];
    acc_next = (s2_first ? '0 : acc) + wsum;
  end

  logic                       s3_v, s3_relu;
  logic signed [SUM_BITS-1:0] s3_fin;
  logic [4:0]                 s3_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch       <= '0;
      s1_v     <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_relu  <= 1'b0;
      s1_bias  <= '0;
      s1_shift <= '0;
      for (int i = 0; i < TAPS; i++) s1_prod[i] <= '0;
      s2_v     <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_relu  <= 1'b0;
      s2_bias  <= '0;
      s2_shift <= '0;
      for (int r = 0; r < K; r++) s2_row[r] <= '0;
      acc      <= '0;
      s3_v     <= 1'b0;
      s3_relu  <= 1'b0;
      s3_fin   <= '0;
      s3_shift <= '0;
    end else if (en) begin
      if (accept) ch <= (ch == CH_LAST) ? '0 : ch + 1'b1;
      s1_v     <= accept;
      s1_first <= accept && first_in;
      s1_last  <= accept && last_in;
      s1_relu  <= relu_en;
      s1_bias  <= bias;
      s1_shift <= shift;
      for (int i = 0; i < TAPS; i++) s1_prod[i] <= prod_c[i];
      s2_v     <= s1_v;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_relu  <= s1_relu;
      s2_bias  <= s1_bias;
      s2_shift <= s1_shift;
      for (int r = 0; r < K; r++) s2_row[r] <= row_c[r];
      if (s2_v) acc <= acc_next;
      s3_v <= s2_v && s2_last;
      if (s2_v && s2_last) begin
        s3_fin   <= acc_next + s2_bias;
        s3_relu  <= s2_relu;
        s3_shift <= s2_shift;
      end
    end
  end

  conv_requant #(
    .SUM_BITS (SUM_BITS),
    .OUT_BITS (OUT_BITS)
  ) u_requant (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (s3_v),
    .fin       (s3_fin),
    .relu_en   (s3_relu),
    .shift     (s3_shift),
    .valid_out (valid_out),
    .y         (y),
    .sat       (sat)
  );

endmodule
